// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if
//   Bundles the fetch port, direct write port and streaming load port of
//   the instruction memory.
//   The slave modport is the memory side.
//   The master modport is the core or loader side.
//
// Signals:
//   fetch_en / fetch_addr              fetch request and address
//   fetch_data / fetch_valid           registered fetch result
//   stall                              memory busy (clearing or loading)
//   wr_en / wr_addr / wr_data          direct single-word write
//   load_start / load_base / load_len  start of a streaming load
//   load_abort                         terminate an active load
//   load_valid / load_data             load beat handshake (master side)
//   load_ready                         load beat handshake (slave side)
//   load_done                          one-cycle completion pulse
interface prog_mem_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic              load_abort;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;

    modport slave (
        input  fetch_en, fetch_addr, wr_en, wr_addr, wr_data,
               load_start, load_base, load_len, load_abort,
               load_valid, load_data,
        output fetch_data, fetch_valid, stall, load_ready, load_done
    );

    modport master (
        output fetch_en, fetch_addr, wr_en, wr_addr, wr_data,
               load_start, load_base, load_len, load_abort,
               load_valid, load_data,
        input  fetch_data, fetch_valid, stall, load_ready, load_done
    );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//   This is the instruction memory for the CPU. It has the following ports:
//   - a registered fetch port
//   - a direct single-word write port
//   - a streaming program-load port (valid/ready, auto-incrementing
//     address, length-counted)
//
//   An optional clear sweep zeroes every word after reset.
//   While a clear or load is running, stall is held high so the core
//   never fetches a partly written program.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  prog_mem_loader_if.slave
//        (fetch, direct write and load signals)
module prog_mem_loader #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 6,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    prog_mem_loader_if.slave      bus
);
    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD} state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [ADDR_W:0]   remaining, remaining_nx;
    logic [ADDR_W:0]   len_clamped;
    logic              done_nx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] fetch_data_q;
    logic              fetch_valid_q;
    logic              load_done_q;

    // Lengths larger than the memory would only rewrite the same words.
    // Clamp them to one full pass.
    assign len_clamped = (bus.load_len > DEPTH_LEN) ? DEPTH_LEN : bus.load_len;

    assign bus.stall       = (state != IDLE);
    assign bus.load_ready  = (state == LOAD);
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.load_done   = load_done_q;

    // Next-state logic.
    // All memory writes go through the single write port selected here.
    always_comb begin
        state_nx     = state;
        clr_ptr_nx   = clr_ptr;
        ptr_nx       = ptr;
        remaining_nx = remaining;
        done_nx      = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                if (bus.wr_en) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.wr_addr;
                    mem_wdata = bus.wr_data;
                end
                // load_start takes priority over a simultaneous load_abort.
                // An abort only has meaning inside LOAD.
                if (bus.load_start) begin
                    ptr_nx       = bus.load_base;
                    remaining_nx = len_clamped;
                    if (len_clamped == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_ptr;
                clr_ptr_nx = clr_ptr + 1'b1;
                if (&clr_ptr) begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                // An abort wins over a beat presented in the same cycle.
                if (bus.load_abort) begin
                    state_nx = IDLE;
                end else if (bus.load_valid) begin
                    mem_we       = 1'b1;
                    mem_waddr    = ptr;
                    mem_wdata    = bus.load_data;
                    ptr_nx       = ptr + 1'b1;
                    remaining_nx = remaining - 1'b1;
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, pointers and the registered fetch port.
    // Outside IDLE the fetch port returns a zero word (a NOP) so that
    // nothing stale reaches the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RESET_STATE;
            clr_ptr       <= '0;
            ptr           <= '0;
            remaining     <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            clr_ptr     <= clr_ptr_nx;
            ptr         <= ptr_nx;
            remaining   <= remaining_nx;
            load_done_q <= done_nx;
            if (state == IDLE) begin
                fetch_valid_q <= bus.fetch_en;
                if (bus.fetch_en) begin
                    fetch_data_q <= mem[bus.fetch_addr];
                end
            end else begin
                fetch_valid_q <= 1'b0;
                fetch_data_q  <= '0;
            end
        end
    end

    // The storage array is kept without reset so it maps onto RAM.
    // A fetch in the same cycle as a write sees the old word (read-first).
    // Writes are suppressed while reset is asserted, so a beat presented
    // alongside reset is dropped together with the load.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end
endmodule
